// File: rtl/aixh_mxc_inner_dwd_launcher_if.sv
// Bundles the command stream, row-vector stream and downward cell bus of the
// MxConv inner dwd launcher.
interface aixh_mxc_inner_dwd_launcher_if #(
    parameter int XCELLS = 16,
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 8
);
    logic                     i_cmd_vld;
    logic                     o_cmd_rdy;
    logic [CNT_W-1:0]         i_cmd_nvec;
    logic [CNT_W-1:0]         i_cmd_nrep;
    logic [XCELLS-1:0]        i_cmd_mask;
    logic                     i_vec_vld;
    logic                     o_vec_rdy;
    logic [XCELLS*DWIDTH-1:0] i_vec_dat;
    logic [XCELLS*2-1:0]      o_dwd_vld;
    logic [XCELLS*DWIDTH-1:0] o_dwd_dat;
    logic                     o_busy;
    logic                     o_done;

    modport master (
        output i_cmd_vld, i_cmd_nvec, i_cmd_nrep, i_cmd_mask, i_vec_vld, i_vec_dat,
        input  o_cmd_rdy, o_vec_rdy, o_dwd_vld, o_dwd_dat, o_busy, o_done
    );

    modport slave (
        input  i_cmd_vld, i_cmd_nvec, i_cmd_nrep, i_cmd_mask, i_vec_vld, i_vec_dat,
        output o_cmd_rdy, o_vec_rdy, o_dwd_vld, o_dwd_dat, o_busy, o_done
    );
endinterface

// File: rtl/aixh_mxc_inner_dwd_launcher.sv
// Transmit end of the MxConv inner dwd cell bus: per row vector one LOAD then
// nrep FIRE strobes per enabled cell, optionally skewed into a diagonal wavefront.
module aixh_mxc_inner_dwd_launcher #(
    parameter int XCELLS = 16,
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 8,
    parameter int SKEW   = 1
) (
    input  logic                          aixh_core_clk2x,
    input  logic                          aixh_core_rst,
    aixh_mxc_inner_dwd_launcher_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FIRE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int DRAIN_CYC = (XCELLS - 1) * SKEW;
    localparam int DRN_W     = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [DRN_W-1:0] DRAIN_LEN = DRN_W'(DRAIN_CYC);

    logic [1:0]        state;
    logic [CNT_W-1:0]  nvec_rem;
    logic [CNT_W-1:0]  nrep_q;
    logic [CNT_W-1:0]  rep_cnt;
    logic [XCELLS-1:0] mask_q;
    logic [DRN_W-1:0]  drain_cnt;

    logic cmd_hs;
    logic vec_hs;
    logic iss_ld;
    logic iss_fr;

    assign cmd_hs = bus.i_cmd_vld & (state == ST_IDLE);
    assign vec_hs = bus.i_vec_vld & (state == ST_LOAD);
    assign iss_ld = vec_hs;
    assign iss_fr = (state == ST_FIRE);

    always_ff @(posedge aixh_core_clk2x) begin
        if (aixh_core_rst) begin
            state     <= ST_IDLE;
            nvec_rem  <= '0;
            nrep_q    <= '0;
            rep_cnt   <= '0;
            mask_q    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        mask_q    <= bus.i_cmd_mask;
                        nrep_q    <= bus.i_cmd_nrep;
                        nvec_rem  <= bus.i_cmd_nvec;
                        drain_cnt <= '0;
                        state     <= (bus.i_cmd_nvec != '0) ? ST_LOAD : ST_DRAIN;
                    end
                end
                ST_LOAD: begin
                    if (vec_hs) begin
                        nvec_rem <= nvec_rem - 1'b1;
                        rep_cnt  <= nrep_q;
                        if (nrep_q != '0) begin
                            state <= ST_FIRE;
                        end else if (nvec_rem == CNT_W'(1)) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LEN;
                        end
                    end
                end
                ST_FIRE: begin
                    rep_cnt <= rep_cnt - 1'b1;
                    if (rep_cnt == CNT_W'(1)) begin
                        if (nvec_rem != '0) begin
                            state <= ST_LOAD;
                        end else begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LEN;
                        end
                    end
                end
                default: begin
                    // DRAIN lets the last strobe ripple across the skewed columns
                    if (drain_cnt == '0) state <= ST_IDLE;
                    else                 drain_cnt <= drain_cnt - 1'b1;
                end
            endcase
        end
    end

    assign bus.o_busy    = (state != ST_IDLE);
    assign bus.o_cmd_rdy = (state == ST_IDLE);
    assign bus.o_vec_rdy = (state == ST_LOAD);
    assign bus.o_done    = (state == ST_DRAIN) && (drain_cnt == '0);

    for (genvar gi = 0; gi < XCELLS; gi++) begin : g_col
        localparam int D = gi * SKEW;

        logic              ld_iss;
        logic              fr_iss;
        logic [DWIDTH-1:0] dat_iss;
        logic              ld_p0;
        logic              fr_p0;
        logic [DWIDTH-1:0] dat_p0;
        logic [1:0]        vld_q;
        logic [DWIDTH-1:0] dat_q;

        assign ld_iss  = iss_ld & mask_q[gi];
        assign fr_iss  = iss_fr & mask_q[gi];
        assign dat_iss = bus.i_vec_dat[gi*DWIDTH +: DWIDTH];

        if (D == 0) begin : g_nodly
            assign ld_p0  = ld_iss;
            assign fr_p0  = fr_iss;
            assign dat_p0 = dat_iss;
        end else begin : g_dly
            logic [D-1:0]      ld_sr;
            logic [D-1:0]      fr_sr;
            logic [DWIDTH-1:0] dat_sr [D];

            always_ff @(posedge aixh_core_clk2x) begin
                if (aixh_core_rst) begin
                    ld_sr <= '0;
                    fr_sr <= '0;
                end else begin
                    ld_sr[0] <= ld_iss;
                    fr_sr[0] <= fr_iss;
                    for (int k = 1; k < D; k++) begin
                        ld_sr[k] <= ld_sr[k-1];
                        fr_sr[k] <= fr_sr[k-1];
                    end
                end
            end

            always_ff @(posedge aixh_core_clk2x) begin
                dat_sr[0] <= dat_iss;
                for (int k = 1; k < D; k++) dat_sr[k] <= dat_sr[k-1];
            end

            assign ld_p0  = ld_sr[D-1];
            assign fr_p0  = fr_sr[D-1];
            assign dat_p0 = dat_sr[D-1];
        end

        // Output stage: data only moves on this cell's own LOAD
        always_ff @(posedge aixh_core_clk2x) begin
            if (aixh_core_rst) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q <= {fr_p0, ld_p0};
                if (ld_p0) dat_q <= dat_p0;
            end
        end

        assign bus.o_dwd_vld[2*gi +: 2]         = vld_q;
        assign bus.o_dwd_dat[gi*DWIDTH +: DWIDTH] = dat_q;
    end

endmodule

// File: tb/tb_aixh_mxc_inner_dwd_launcher.sv
// Scoreboard bench for the dwd launcher: a timeline model predicts every
// per-column strobe, data word, busy window and done pulse.
module tb_aixh_mxc_inner_dwd_launcher;

    localparam int X  = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int S  = 1;

    typedef struct {
        int            cyc;
        logic [1:0]    kind;
        logic [DW-1:0] dat;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    aixh_mxc_inner_dwd_launcher_if #(.XCELLS(X), .DWIDTH(DW), .CNT_W(CW)) bus ();

    aixh_mxc_inner_dwd_launcher #(.XCELLS(X), .DWIDTH(DW), .CNT_W(CW), .SKEW(S)) dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rst   (rst),
        .bus             (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t           colq [X][$];
    int            doneq[$];
    logic [DW-1:0] exp_dat [X];
    int            busy_lo   = 1 << 30;
    int            busy_hi   = -1;
    int            done_last = -1;
    logic          exp_vrdy  = 1'b0;
    logic          chk_en    = 1'b0;
    int            n_chk     = 0;
    int            n_fail    = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_accept(input int c0, input int nv);
        busy_lo = c0 + 1;
        busy_hi = 1 << 30;
        if (nv == 0) begin
            doneq.push_back(c0 + 1);
            busy_hi   = c0 + 1;
            done_last = c0 + 1;
        end
    endtask

    // Vector accepted at cycle t: column i sees LOAD at t+1+i*S, then nr FIREs
    task automatic model_load(input int t, input logic [X*DW-1:0] vec, input int nr,
                              input logic [X-1:0] m, input bit last);
        ev_t e;
        for (int i = 0; i < X; i++) begin
            if (m[i]) begin
                e.cyc = t + 1 + i*S; e.kind = 2'b01; e.dat = vec[i*DW +: DW];
                colq[i].push_back(e);
                for (int j = 1; j <= nr; j++) begin
                    e.cyc = t + 1 + j + i*S; e.kind = 2'b10;
                    colq[i].push_back(e);
                end
            end
        end
        if (last) begin
            done_last = t + nr + 1 + (X-1)*S;
            doneq.push_back(done_last);
            busy_hi = done_last;
        end
    endtask

    task automatic run_cmd(input int nv, input int nr, input logic [X-1:0] m,
                           input int pct, input int gap0);
        int c0;
        int avail;
        logic [X*DW-1:0] d;
        bus.i_cmd_vld  = 1'b1;
        bus.i_cmd_nvec = CW'(nv);
        bus.i_cmd_nrep = CW'(nr);
        bus.i_cmd_mask = m;
        exp_vrdy = 1'b0;
        while (cyc < done_last + 1) step();
        c0 = cyc;
        model_accept(c0, nv);
        step();
        bus.i_cmd_vld  = 1'b0;
        bus.i_cmd_nvec = CW'($urandom);
        bus.i_cmd_nrep = CW'($urandom);
        bus.i_cmd_mask = X'($urandom);
        avail = c0 + 1;
        for (int k = 0; k < nv; k++) begin
            forever begin
                d = $urandom;
                bus.i_vec_dat = d;
                exp_vrdy = (cyc >= avail);
                if (cyc < avail)
                    bus.i_vec_vld = 1'($urandom_range(1));
                else if (k == 0 && cyc < avail + gap0)
                    bus.i_vec_vld = 1'b0;
                else
                    bus.i_vec_vld = ($urandom_range(99) < pct);
                if (bus.i_vec_vld && cyc >= avail) begin
                    model_load(cyc, d, nr, m, k == nv - 1);
                    avail = cyc + 1 + nr;
                    step();
                    break;
                end
                step();
            end
        end
        bus.i_vec_vld = 1'b0;
        exp_vrdy = 1'b0;
    endtask

    // Monitor: pops per-column and done expectations as the DUT presents them
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < X; i++) begin : mon_col
                logic [1:0] v;
                v = bus.o_dwd_vld[2*i +: 2];
                while (colq[i].size() > 0 && colq[i][0].cyc < cyc) begin
                    n_chk++; n_fail++;
                    $display("FAIL col%0d_missing: got nothing at cycle %0d expected kind %b",
                             i, colq[i][0].cyc, colq[i][0].kind);
                    void'(colq[i].pop_front());
                end
                if (v != 2'b00) begin
                    n_chk++;
                    if (colq[i].size() == 0 || colq[i][0].cyc != cyc || colq[i][0].kind != v) begin
                        n_fail++;
                        $display("FAIL col%0d_vld @cycle %0d: got %b expected %s", i, cyc, v,
                                 (colq[i].size() > 0 && colq[i][0].cyc == cyc) ? "other kind" : "00");
                        if (colq[i].size() > 0 && colq[i][0].cyc == cyc) void'(colq[i].pop_front());
                    end else begin
                        if (v == 2'b01) exp_dat[i] = colq[i][0].dat;
                        void'(colq[i].pop_front());
                    end
                end
                chk($sformatf("col%0d_dat", i), 64'(bus.o_dwd_dat[i*DW +: DW]), 64'(exp_dat[i]));
            end
            chk("busy",    64'(bus.o_busy),    64'(cyc >= busy_lo && cyc <= busy_hi));
            chk("cmd_rdy", 64'(bus.o_cmd_rdy), 64'(!(cyc >= busy_lo && cyc <= busy_hi)));
            chk("vec_rdy", 64'(bus.o_vec_rdy), 64'(exp_vrdy));
            while (doneq.size() > 0 && doneq[0] < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL done_missing: got no pulse expected at cycle %0d", doneq[0]);
                void'(doneq.pop_front());
            end
            if (bus.o_done) begin
                n_chk++;
                if (doneq.size() == 0 || doneq[0] != cyc) begin
                    n_fail++;
                    $display("FAIL done_pulse: got pulse at cycle %0d expected %0d", cyc,
                             (doneq.size() > 0) ? doneq[0] : -1);
                end else begin
                    void'(doneq.pop_front());
                end
            end
        end
    end

    initial begin
        int c0;
        logic [X*DW-1:0] d;
        bus.i_cmd_vld = 1'b0; bus.i_cmd_nvec = '0; bus.i_cmd_nrep = '0; bus.i_cmd_mask = '0;
        bus.i_vec_vld = 1'b0; bus.i_vec_dat = '0;
        for (int i = 0; i < X; i++) exp_dat[i] = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_cmd_rdy", 64'(bus.o_cmd_rdy), 64'd1);
        chk("rst_busy",    64'(bus.o_busy),    64'd0);
        chk("rst_vec_rdy", 64'(bus.o_vec_rdy), 64'd0);
        chk("rst_done",    64'(bus.o_done),    64'd0);
        chk("rst_vld",     64'(bus.o_dwd_vld), 64'd0);
        chk("rst_dat",     64'(bus.o_dwd_dat), 64'd0);
        chk_en = 1'b1;

        // Reset in the middle of a load/fire command
        c0 = cyc;
        bus.i_cmd_vld = 1'b1; bus.i_cmd_nvec = 8'd1; bus.i_cmd_nrep = 8'd2; bus.i_cmd_mask = 4'hF;
        model_accept(c0, 1);
        step();
        bus.i_cmd_vld = 1'b0;
        d = 32'h44332211;
        bus.i_vec_vld = 1'b1; bus.i_vec_dat = d; exp_vrdy = 1'b1;
        model_load(cyc, d, 2, 4'hF, 1'b1);
        step();
        bus.i_vec_vld = 1'b0; exp_vrdy = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < X; i++) begin
            colq[i].delete();
            exp_dat[i] = '0;
        end
        doneq.delete();
        busy_lo = 1 << 30; busy_hi = -1; done_last = cyc - 1;
        chk("mrst_vld",     64'(bus.o_dwd_vld), 64'd0);
        chk("mrst_dat",     64'(bus.o_dwd_dat), 64'd0);
        chk("mrst_busy",    64'(bus.o_busy),    64'd0);
        chk("mrst_cmd_rdy", 64'(bus.o_cmd_rdy), 64'd1);

        run_cmd(0, 0, 4'hF, 100, 0);
        run_cmd(1, 2, 4'hF, 100, 0);
        run_cmd(1, 2, 4'hF, 100, 3);
        run_cmd(3, 0, 4'hF, 100, 0);
        run_cmd(1, 2, 4'b0101, 100, 0);
        run_cmd(0, 3, 4'hA, 100, 0);
        run_cmd(255, 0, 4'hF, 100, 0);
        run_cmd(2, 255, 4'b1001, 70, 1);
        for (int n = 0; n < 40; n++)
            run_cmd($urandom_range(0, 4), $urandom_range(0, 3), X'($urandom),
                    $urandom_range(30, 100), $urandom_range(0, 2));

        while (cyc <= done_last + 2) step();
        for (int i = 0; i < X; i++)
            chk($sformatf("col%0d_left", i), 64'(colq[i].size()), 64'd0);
        chk("done_left", 64'(doneq.size()), 64'd0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
